id_witf_scoreboard: RTL and testbench

- Decode-stage hazard unit and handshake controller for the in-order NPC pipeline.
- Holds a write-in-flight FIFO (WITF) of destination registers for instructions that have dispatched to EXU and not yet written back.
- Stalls ID on RAW hazards or when the WITF is full, suppresses dispatch on pipeline flush, and retires entries in order on writeback.
- Replaces the fixed "always ready" ID handshake with a parametrised, depth-configurable scoreboard.

---
 rtl/id_witf_scoreboard_pkg.sv | 12 +
 rtl/id_witf_scoreboard_witf_fifo.sv | 89 ++++++++
 rtl/id_witf_scoreboard.sv | 107 ++++++++++
 tb/tb_id_witf_scoreboard.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/id_witf_scoreboard_pkg.sv
// Shared defaults and helpers for the ID write-in-flight scoreboard.
package id_witf_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned WITF_DEPTH_DEF = 4;

    // Occupancy needs one more bit than the pointers so that "full" is representable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/id_witf_scoreboard_witf_fifo.sv
// Write-in-flight FIFO: in-order list of destination registers awaiting writeback.
// Exposes every entry (valid + rd) so the hazard unit can compare all of them in parallel.
module id_witf_scoreboard_witf_fifo
    import id_witf_scoreboard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned WITF_DEPTH = WITF_DEPTH_DEF,
    localparam int unsigned CNT_W = cnt_width(WITF_DEPTH),
    localparam int unsigned PTR_W = $clog2(WITF_DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  push,
    input  logic [REG_ADDR_W-1:0]                 push_rd,
    input  logic                                  pop,
    output logic [WITF_DEPTH-1:0]                 ent_valid,
    output logic [WITF_DEPTH-1:0][REG_ADDR_W-1:0] ent_rd,
    output logic [PTR_W-1:0]                      head,
    output logic [REG_ADDR_W-1:0]                 head_rd,
    output logic [CNT_W-1:0]                      count,
    output logic                                  full,
    output logic                                  empty
);

    logic [WITF_DEPTH-1:0]                 valid_q, valid_d;
    logic [WITF_DEPTH-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0]                      head_q, head_d;
    logic [PTR_W-1:0]                      tail_q, tail_d;
    logic [CNT_W-1:0]                      count_q, count_d;
    logic                                  push_en, pop_en;

    // Occupancy flags come from the counter, never from pointer comparison.
    always_comb begin
        full    = (count_q == CNT_W'(WITF_DEPTH));
        empty   = (count_q == '0);
        push_en = push & ~full;
        pop_en  = pop & ~empty;
    end

    // Next-state: pop clears the head slot, push fills the tail slot; pointers wrap by width.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_en) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push_en) begin
            valid_d[tail_q] = 1'b1;
            rd_d[tail_q]    = push_rd;
            tail_d          = tail_q + 1'b1;
        end
        if (push_en && !pop_en) begin
            count_d = count_q + 1'b1;
        end else if (pop_en && !push_en) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rd_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry view for the parallel compare.
    always_comb begin
        ent_valid = valid_q;
        ent_rd    = rd_q;
        head      = head_q;
        head_rd   = rd_q[head_q];
        count     = count_q;
    end

endmodule

// File: rtl/id_witf_scoreboard.sv
// ID-stage hazard unit and handshake controller backed by a write-in-flight FIFO.
// Optional macro WITF_BYPASS_EN: a hit on the head entry alone is masked during that
// entry's writeback cycle, relying on register-file write-through.
module id_witf_scoreboard
    import id_witf_scoreboard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned WITF_DEPTH = WITF_DEPTH_DEF,
    localparam int unsigned CNT_W = cnt_width(WITF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    output logic                  id_ready,
    output logic                  id_to_exu_valid,
    input  logic                  exu_allow_in,
    input  logic                  pipeline_flush,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_wr,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  raw_stall,
    output logic                  witf_full,
    output logic                  witf_empty,
    output logic [CNT_W-1:0]      witf_count,
    output logic                  order_err
);

    localparam int unsigned PTR_W = $clog2(WITF_DEPTH);

    logic [WITF_DEPTH-1:0]                 ent_valid;
    logic [WITF_DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
    logic [PTR_W-1:0]                      head;
    logic [REG_ADDR_W-1:0]                 head_rd;
    logic [WITF_DEPTH-1:0]                 match1, match2;
    logic                                  hit1, hit2, needs_push, ready_go, push, pop;
    logic                                  order_err_q, order_err_d;

    id_witf_scoreboard_witf_fifo #(
        .REG_ADDR_W (REG_ADDR_W),
        .WITF_DEPTH (WITF_DEPTH)
    ) u_witf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (rd),
        .pop       (pop),
        .ent_valid (ent_valid),
        .ent_rd    (ent_rd),
        .head      (head),
        .head_rd   (head_rd),
        .count     (witf_count),
        .full      (witf_full),
        .empty     (witf_empty)
    );

    // Parallel source compare against every valid in-flight destination.
    always_comb begin
        for (int i = 0; i < int'(WITF_DEPTH); i++) begin
            match1[i] = ent_valid[i] & (ent_rd[i] == rs1);
            match2[i] = ent_valid[i] & (ent_rd[i] == rs2);
        end
`ifdef WITF_BYPASS_EN
        // Head is writing back now; any younger match still holds the hit.
        if (wb_valid) begin
            match1[head] = 1'b0;
            match2[head] = 1'b0;
        end
`endif
    end

    // Hazard detection and the ID/EXU handshake; no path from wb_valid to the full check.
    always_comb begin
        needs_push      = reg_wr & (rd != '0);
        hit1            = rs1_used & (rs1 != '0) & (|match1);
        hit2            = rs2_used & (rs2 != '0) & (|match2);
        raw_stall       = id_valid & (hit1 | hit2);
        ready_go        = ~raw_stall & ~(needs_push & witf_full);
        id_to_exu_valid = id_valid & ready_go & ~pipeline_flush;
        id_ready        = ~id_valid | pipeline_flush | (ready_go & exu_allow_in);
        push            = id_to_exu_valid & exu_allow_in & needs_push;
        pop             = wb_valid & ~witf_empty;
    end

    // Sticky ordering error: writeback with nothing in flight or not matching the head.
    always_comb begin
        order_err_d = order_err_q;
        if (wb_valid && (witf_empty || (wb_rd != head_rd))) begin
            order_err_d = 1'b1;
        end
        order_err = order_err_q;
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order_err_q <= 1'b0;
        end else begin
            order_err_q <= order_err_d;
        end
    end

endmodule

// File: tb/tb_id_witf_scoreboard.sv
// Bench for id_witf_scoreboard: directed vector table followed by randomized traffic
// checked against a queue-based reference model.
module tb_id_witf_scoreboard;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_ready, id_to_exu_valid, exu_allow_in, pipeline_flush;
    logic [4:0] rs1, rs2, rd, wb_rd;
    logic       rs1_used, rs2_used, reg_wr, wb_valid;
    logic       raw_stall, witf_full, witf_empty, order_err;
    logic [2:0] witf_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    id_witf_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_to_exu_valid (id_to_exu_valid),
        .exu_allow_in    (exu_allow_in),
        .pipeline_flush  (pipeline_flush),
        .rs1             (rs1),
        .rs2             (rs2),
        .rs1_used        (rs1_used),
        .rs2_used        (rs2_used),
        .rd              (rd),
        .reg_wr          (reg_wr),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .raw_stall       (raw_stall),
        .witf_full       (witf_full),
        .witf_empty      (witf_empty),
        .witf_count      (witf_count),
        .order_err       (order_err)
    );

    typedef struct {
        int iv, al, fl, rs1, u1, rs2, u2, rd, wr, wbv, wbrd;
        int tx, rdy, st, cnt, err;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: destinations in flight, oldest first.
    int q[$];
    bit m_err;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    endtask

    function automatic vec_t mk(input int iv, al, fl, r1, u1, r2, u2, d, wr, wbv, wbrd,
                                input int tx, rdy, st, cnt, err);
        vec_t v;
        v.iv = iv; v.al = al; v.fl = fl; v.rs1 = r1; v.u1 = u1; v.rs2 = r2; v.u2 = u2;
        v.rd = d; v.wr = wr; v.wbv = wbv; v.wbrd = wbrd;
        v.tx = tx; v.rdy = rdy; v.st = st; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        id_valid       = 1'(v.iv);
        exu_allow_in   = 1'(v.al);
        pipeline_flush = 1'(v.fl);
        rs1            = 5'(v.rs1);
        rs1_used       = 1'(v.u1);
        rs2            = 5'(v.rs2);
        rs2_used       = 1'(v.u2);
        rd             = 5'(v.rd);
        reg_wr         = 1'(v.wr);
        wb_valid       = 1'(v.wbv);
        wb_rd          = 5'(v.wbrd);
    endtask

    task automatic idle_inputs();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // True if r is an in-flight destination; optionally ignore the oldest entry.
    function automatic bit in_flight(input int r, input bit skip_head);
        for (int i = (skip_head ? 1 : 0); i < q.size(); i++)
            if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_empty", 0, int'(witf_empty), 1);
        chk("rst_full", 0, int'(witf_full), 0);
        chk("rst_count", 0, int'(witf_count), 0);
        chk("rst_stall", 0, int'(raw_stall), 0);
        chk("rst_err", 0, int'(order_err), 0);
        chk("rst_ready", 0, int'(id_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // iv al fl rs1 u1 rs2 u2 rd wr wbv wbrd | tx rdy st cnt err
        vecs.push_back(mk(1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0,   1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0));
`ifdef WITF_BYPASS_EN
        vecs.push_back(mk(1, 1, 0, 5, 1, 0, 0, 0, 0, 1, 5,   1, 1, 0, 1, 0));
`else
        vecs.push_back(mk(1, 1, 0, 5, 1, 0, 0, 0, 0, 1, 5,   0, 0, 1, 1, 0));
`endif
        vecs.push_back(mk(1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
        for (int r = 1; r <= 4; r++)
            vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, r, 1, 0, 0,   1, 1, 0, r - 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6, 1, 0, 0,   0, 0, 0, 4, 0));
        vecs.push_back(mk(1, 1, 0, 7, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 4, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6, 1, 1, 1,   0, 0, 0, 4, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6, 1, 0, 0,   1, 1, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2,   0, 1, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   0, 1, 0, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8, 1, 1, 4,   1, 1, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 2, 0));
        vecs.push_back(mk(1, 1, 1, 6, 1, 0, 0, 9, 1, 0, 0,   0, 1, 1, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9,   0, 1, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8,   0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1));

        foreach (vecs[i]) begin
            apply(vecs[i]);
            @(negedge clk);
            chk("vec_tx", i, int'(id_to_exu_valid), vecs[i].tx);
            chk("vec_ready", i, int'(id_ready), vecs[i].rdy);
            chk("vec_stall", i, int'(raw_stall), vecs[i].st);
            chk("vec_count", i, int'(witf_count), vecs[i].cnt);
            chk("vec_full", i, int'(witf_full), int'(vecs[i].cnt == DEPTH));
            chk("vec_empty", i, int'(witf_empty), int'(vecs[i].cnt == 0));
            chk("vec_err", i, int'(order_err), vecs[i].err);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset must clear the sticky error without waiting for a clock edge.
        idle_inputs();
        rst = 1'b1;
        #2;
        chk("async_rst_err", 0, int'(order_err), 0);
        chk("async_rst_empty", 0, int'(witf_empty), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_err = 1'b0;

        for (int c = 0; c < 600; c++) begin
            bit hit1, hit2, st, np, go, tx, rdy, byp;
            id_valid       = ($urandom_range(0, 3) != 0);
            exu_allow_in   = ($urandom_range(0, 3) != 0);
            pipeline_flush = ($urandom_range(0, 7) == 0);
            rs1            = 5'($urandom_range(0, 7));
            rs2            = 5'($urandom_range(0, 7));
            rs1_used       = 1'($urandom_range(0, 1));
            rs2_used       = 1'($urandom_range(0, 1));
            rd             = 5'($urandom_range(0, 7));
            reg_wr         = 1'($urandom_range(0, 1));
            if (q.size() > 0) wb_valid = ($urandom_range(0, 3) == 0);
            else              wb_valid = ($urandom_range(0, 15) == 0);
            if (q.size() > 0 && $urandom_range(0, 15) != 0) wb_rd = 5'(q[0]);
            else                                            wb_rd = 5'($urandom_range(0, 7));

`ifdef WITF_BYPASS_EN
            byp = wb_valid;
`else
            byp = 1'b0;
`endif
            hit1 = rs1_used && rs1 != 0 && in_flight(int'(rs1), byp);
            hit2 = rs2_used && rs2 != 0 && in_flight(int'(rs2), byp);
            st   = id_valid && (hit1 || hit2);
            np   = reg_wr && rd != 0;
            go   = !st && !(np && q.size() == DEPTH);
            tx   = id_valid && go && !pipeline_flush;
            rdy  = !id_valid || pipeline_flush || (go && exu_allow_in);

            @(negedge clk);
            chk("rnd_tx", c, int'(id_to_exu_valid), int'(tx));
            chk("rnd_ready", c, int'(id_ready), int'(rdy));
            chk("rnd_stall", c, int'(raw_stall), int'(st));
            chk("rnd_count", c, int'(witf_count), q.size());
            chk("rnd_full", c, int'(witf_full), int'(q.size() == DEPTH));
            chk("rnd_empty", c, int'(witf_empty), int'(q.size() == 0));
            chk("rnd_err", c, int'(order_err), int'(m_err));
            @(posedge clk);
            #1;
            if (wb_valid) begin
                if (q.size() == 0) m_err = 1'b1;
                else begin
                    if (q[0] != int'(wb_rd)) m_err = 1'b1;
                    void'(q.pop_front());
                end
            end
            if (tx && exu_allow_in && np) q.push_back(int'(rd));
        end

        idle_inputs();
        @(negedge clk);
        chk("final_count", 0, int'(witf_count), q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
